// File: rtl/uart_pkg.sv
// Shared UART-side definitions: byte/command widths, link timing constants,
// and the state type of the command assembler.
package uart_pkg;

    localparam int unsigned BYTE_W          = 8;
    localparam int unsigned CMD_W           = 16;
    localparam int unsigned CLK_PER_BIT     = 5208;
    localparam int unsigned TIMEOUT_CYC_DEF = 104160;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        CMD
    } asm_state_t;

endpackage

// File: rtl/uart_cmd_assembler_if.sv
// Handshake bundle between UART_rx, the command assembler and the command
// processor. The slave view is the assembler; the master view is its environment.
interface uart_cmd_assembler_if;
    import uart_pkg::*;

    logic              rx_rdy;
    logic [BYTE_W-1:0] rx_data;
    logic              rx_clr_rdy;
    logic [CMD_W-1:0]  cmd;
    logic              cmd_rdy;
    logic              clr_cmd_rdy;

    modport master (
        output rx_rdy,
        output rx_data,
        output clr_cmd_rdy,
        input  rx_clr_rdy,
        input  cmd,
        input  cmd_rdy
    );

    modport slave (
        input  rx_rdy,
        input  rx_data,
        input  clr_cmd_rdy,
        output rx_clr_rdy,
        output cmd,
        output cmd_rdy
    );

endinterface

// File: rtl/uart_byte_timer.sv
// Saturating up-counter with synchronous clear and a terminal-count flag;
// it stops at TC_VAL so a long idle period can never wrap back to zero.
module uart_byte_timer #(
    parameter int unsigned      CNT_W  = 8,
    parameter logic [CNT_W-1:0] TC_VAL = '1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && (cnt != TC_VAL)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/uart_cmd_assembler.sv
// Pairs two consecutive UART bytes (high first) into a 16-bit command with a
// ready/clear handshake; a lone high byte is dropped after TIMEOUT_CYC clocks.
module uart_cmd_assembler
    import uart_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int unsigned CNT_W       = $clog2(TIMEOUT_CYC)
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_cmd_assembler_if.slave  bus,
    output logic                 frame_busy,
    output logic                 timeout_err
);

    asm_state_t state;
    logic       take;
    logic       tmr_tc;

    // rx_clr_rdy still high means UART_rx has not yet dropped rdy for the last byte.
    always_comb begin
        take = bus.rx_rdy & ~bus.rx_clr_rdy & (state != CMD);
    end

    uart_byte_timer #(
        .CNT_W  (CNT_W),
        .TC_VAL (CNT_W'(TIMEOUT_CYC - 1))
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (state != HIGH),
        .en  (state == HIGH),
        .tc  (tmr_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            bus.cmd        <= '0;
            bus.cmd_rdy    <= 1'b0;
            bus.rx_clr_rdy <= 1'b0;
            frame_busy     <= 1'b0;
            timeout_err    <= 1'b0;
        end else begin
            bus.rx_clr_rdy <= take;
            timeout_err    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (take) begin
                        bus.cmd[CMD_W-1:BYTE_W] <= bus.rx_data;
                        frame_busy              <= 1'b1;
                        state                   <= HIGH;
                    end
                end
                HIGH: begin
                    // A byte arriving on the terminal count still completes the frame.
                    if (take) begin
                        bus.cmd[BYTE_W-1:0] <= bus.rx_data;
                        bus.cmd_rdy         <= 1'b1;
                        frame_busy          <= 1'b0;
                        state               <= CMD;
                    end else if (tmr_tc) begin
                        timeout_err <= 1'b1;
                        frame_busy  <= 1'b0;
                        state       <= IDLE;
                    end
                end
                CMD: begin
                    if (bus.clr_cmd_rdy) begin
                        bus.cmd_rdy <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    bus.cmd_rdy <= 1'b0;
                    frame_busy  <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Randomized and directed bench for uart_cmd_assembler, checked every cycle
// against a frame-level reference model plus literal spot checks.
module tb_uart_cmd_assembler;

    localparam int unsigned T = 8;

    logic clk = 1'b0;
    logic rst;
    logic frame_busy;
    logic timeout_err;
    bit   rand_mode;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    // reference model: pending high byte and its age, assembled word, ack flags
    logic [15:0] m_cmd;
    bit          m_rdy, m_clr, m_busy, m_terr, armed, m_take;
    int unsigned m_age;

    // event tallies taken from DUT outputs
    int unsigned clr_pulses = 0;
    int unsigned terr_pulses = 0;
    int unsigned rdy_cycles = 0;

    uart_cmd_assembler_if bus ();

    uart_cmd_assembler #(
        .TIMEOUT_CYC (T)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .frame_busy  (frame_busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        forever begin
            @(posedge clk);
            if (rst) begin
                m_cmd = '0; m_rdy = 0; m_clr = 0; m_busy = 0; m_terr = 0; m_age = 0;
                armed = 1;
            end else begin
                m_take = bus.rx_rdy && !m_clr && !m_rdy;
                m_clr  = m_take;
                m_terr = 0;
                if (m_rdy) begin
                    if (bus.clr_cmd_rdy) m_rdy = 0;
                end else if (m_busy) begin
                    if (m_take) begin
                        m_cmd[7:0] = bus.rx_data; m_rdy = 1; m_busy = 0;
                    end else if (m_age == T - 1) begin
                        m_terr = 1; m_busy = 0;
                    end else begin
                        m_age++;
                    end
                end else if (m_take) begin
                    m_cmd[15:8] = bus.rx_data; m_busy = 1; m_age = 0;
                end
            end
            #1;
            if (armed) begin
                chk("cmd",         32'(bus.cmd),        32'(m_cmd));
                chk("cmd_rdy",     32'(bus.cmd_rdy),    32'(m_rdy));
                chk("rx_clr_rdy",  32'(bus.rx_clr_rdy), 32'(m_clr));
                chk("frame_busy",  32'(frame_busy),     32'(m_busy));
                chk("timeout_err", 32'(timeout_err),    32'(m_terr));
                if (bus.rx_clr_rdy === 1'b1) clr_pulses++;
                if (timeout_err === 1'b1)    terr_pulses++;
                if (bus.cmd_rdy === 1'b1)    rdy_cycles++;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (rand_mode) bus.clr_cmd_rdy = ($urandom_range(0, 3) == 0);
    endtask

    // Behaves like UART_rx: hold rdy until acknowledged, optionally one cycle longer.
    task automatic send_byte(input logic [7:0] b, input bit extra);
        int unsigned n = 0;
        bus.rx_rdy  = 1'b1;
        bus.rx_data = b;
        do begin
            tick();
            n++;
        end while (bus.rx_clr_rdy !== 1'b1 && n < 200);
        if (bus.rx_clr_rdy !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL send_ack: got no rx_clr_rdy for byte %h, expected one within 200 clk", b);
        end
        if (extra) tick();
        bus.rx_rdy  = 1'b0;
        bus.rx_data = 8'($urandom);
    endtask

    task automatic pulse_clr();
        bus.clr_cmd_rdy = 1'b1;
        @(negedge clk);
        bus.clr_cmd_rdy = 1'b0;
    endtask

    initial begin
        int unsigned c0, t0, r0;
        rst = 1'b1; rand_mode = 0; armed = 0;
        bus.rx_rdy = 1'b0; bus.rx_data = '0; bus.clr_cmd_rdy = 1'b0;
        fork monitor(); join_none
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_cmd", 32'(bus.cmd), 32'h0000);
        chk("reset_busy", 32'(frame_busy), 0);

        // back-to-back pair
        c0 = clr_pulses; t0 = terr_pulses;
        send_byte(8'hA5, 0);
        send_byte(8'h3C, 0);
        tick();
        chk("pair_cmd", 32'(bus.cmd), 32'hA53C);
        chk("pair_rdy", 32'(bus.cmd_rdy), 1);
        chk("pair_acks", clr_pulses - c0, 2);
        chk("pair_noterr", terr_pulses - t0, 0);

        // byte waits in UART_rx while cmd is held
        fork
            send_byte(8'h12, 0);
            begin
                repeat (6) @(negedge clk);
                chk("hold_cmd", 32'(bus.cmd), 32'hA53C);
                chk("hold_rdy", 32'(bus.cmd_rdy), 1);
                pulse_clr();
                chk("hold_cleared", 32'(bus.cmd_rdy), 0);
            end
        join
        chk("hold_hi_busy", 32'(frame_busy), 1);
        chk("hold_hi_cmd", 32'(bus.cmd), 32'h123C);
        send_byte(8'h34, 1);
        chk("hold_next_cmd", 32'(bus.cmd), 32'h1234);
        pulse_clr();

        // stale high byte dropped
        t0 = terr_pulses;
        send_byte(8'hFF, 0);
        repeat (T + 2) tick();
        chk("to_pulse", terr_pulses - t0, 1);
        chk("to_busy", 32'(frame_busy), 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        chk("to_cmd", 32'(bus.cmd), 32'h0001);
        pulse_clr();

        // low byte on the terminal count wins
        t0 = terr_pulses;
        send_byte(8'h5E, 0);
        repeat (T - 1) @(negedge clk);
        bus.rx_rdy = 1'b1; bus.rx_data = 8'h77;
        @(negedge clk);
        bus.rx_rdy = 1'b0;
        chk("tc_rdy", 32'(bus.cmd_rdy), 1);
        chk("tc_cmd", 32'(bus.cmd), 32'h5E77);
        chk("tc_noterr", terr_pulses - t0, 0);
        pulse_clr();

        // one cycle later the frame has already timed out
        send_byte(8'h5E, 0);
        repeat (T) @(negedge clk);
        bus.rx_rdy = 1'b1; bus.rx_data = 8'h66;
        @(negedge clk);
        bus.rx_rdy = 1'b0;
        chk("late_terr", terr_pulses - t0, 1);
        chk("late_busy", 32'(frame_busy), 1);
        chk("late_cmd", 32'(bus.cmd), 32'h6677);
        send_byte(8'h99, 0);
        chk("late_pair", 32'(bus.cmd), 32'h6699);
        pulse_clr();

        // reset during HIGH
        send_byte(8'hC3, 0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_cmd", 32'(bus.cmd), 32'h0000);
        chk("rst_busy", 32'(frame_busy), 0);
        chk("rst_ack", 32'(bus.rx_clr_rdy), 0);
        send_byte(8'h5A, 0);
        send_byte(8'hA5, 1);
        chk("rst_pair", 32'(bus.cmd), 32'h5AA5);
        pulse_clr();

        // clear held across CMD entry
        bus.clr_cmd_rdy = 1'b1;
        r0 = rdy_cycles;
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        tick();
        chk("held_rdy_cycles", rdy_cycles - r0, 1);
        chk("held_cmd", 32'(bus.cmd), 32'h0102);
        chk("held_idle", 32'({bus.cmd_rdy, frame_busy}), 0);
        bus.clr_cmd_rdy = 1'b0;

        // randomized traffic
        rand_mode = 1;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 7))
                0, 1, 2, 3, 4: send_byte(8'($urandom), 1'($urandom));
                5, 6:          repeat ($urandom_range(1, 12)) tick();
                default: begin
                    if ($urandom_range(0, 7) == 0) begin
                        rst = 1'b1;
                        tick();
                        rst = 1'b0;
                    end else begin
                        tick();
                    end
                end
            endcase
        end
        rand_mode = 0;
        bus.clr_cmd_rdy = 1'b0;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
